// File: rtl/pwm_dcdr_pkg.sv
// Shared types and defaults for the PWM speed decoder and the motor driver.
package pwm_dcdr_pkg;
  localparam int PERIOD_DEF  = 2048;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {IDLE, HIGH_FWD, HIGH_REV, LOW} state_e;

  typedef logic signed [11:0] spd_t;

  // Reverse speed is the one's complement so cnt 1 -> -2 and cnt 2047 -> -2048.
  function automatic spd_t spd_of(input logic rev, input logic [10:0] cnt);
    return rev ? ~{1'b0, cnt} : {1'b0, cnt};
  endfunction
endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus edge-detect flop for one asynchronous PWM pin.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q, sync_d;
  logic [1:0] vld_pipe_q, vld_pipe_d;
  logic       armed_q, armed_d;

  // Arm only once a valid low has been synchronized, so a pulse already in
  // progress when reset releases is never measured.
  always_comb begin
    sync_d     = {sync_q[1:0], pwm_i};
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
    armed_d    = armed_q | (vld_pipe_q[1] & ~sync_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      armed_q    <= armed_d;
    end
  end

  assign lvl_o  = armed_q &  sync_q[1];
  assign rise_o = armed_q &  sync_q[1] & ~sync_q[2];
  assign fall_o = armed_q & ~sync_q[1] &  sync_q[2];
endmodule

// File: rtl/pwm_dcdr.sv
// Reconstructs signed motor speed from H-bridge PWM high time, with period,
// coast, stuck-high and direction-conflict reporting.
module pwm_dcdr
  import pwm_dcdr_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PWM1,
  input  logic        PWM2,
  output spd_t        spd,
  output logic        spd_vld,
  output logic [11:0] period,
  output logic        coast,
  output logic        stuck,
  output logic        dir_err
);
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_HIT  = TO_W'(TIMEOUT - 1);
  localparam logic [10:0]     CNT_MAX = 11'(PERIOD - 1);

  logic [1:0] pwm_in, lvl, rise, fall;
  assign pwm_in = {PWM2, PWM1};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    pwm_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .pwm_i (pwm_in[i]),
      .lvl_o (lvl[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  state_e          state_q, state_d;
  logic [10:0]     hcnt_q, hcnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [11:0]     pcnt_q, pcnt_d, period_q, period_d;
  logic            pvld_q, pvld_d;
  logic            upd_q, upd_d;
  spd_t            upd_spd_q, upd_spd_d, spd_q, spd_d;
  logic            spd_vld_q, spd_vld_d;
  logic            coast_q, coast_d, stuck_q, stuck_d, dir_err_q, dir_err_d;

  logic rev, act_lvl, act_fall, oth_rise;
  assign rev      = (state_q == HIGH_REV);
  assign act_lvl  = rev ? lvl[1]  : lvl[0];
  assign act_fall = rev ? fall[1] : fall[0];
  assign oth_rise = rev ? rise[0] : rise[1];

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    to_d      = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
    pcnt_d    = (&pcnt_q) ? pcnt_q : pcnt_q + 12'd1;
    pvld_d    = pvld_q;
    period_d  = period_q;
    upd_d     = 1'b0;
    upd_spd_d = upd_spd_q;
    coast_d   = coast_q;
    stuck_d   = stuck_q;
    dir_err_d = dir_err_q;

    if (|rise) begin
      pcnt_d  = 12'd1;
      pvld_d  = 1'b1;
      coast_d = 1'b0;
      to_d    = '0;
      if (pvld_q) period_d = pcnt_q;
    end

    case (state_q)
      IDLE, LOW: begin
        if (&lvl) begin
          dir_err_d = 1'b1;
          state_d   = IDLE;
        end else if (rise[0]) begin
          state_d = HIGH_FWD;
          hcnt_d  = 11'd1;
        end else if (rise[1]) begin
          state_d = HIGH_REV;
          hcnt_d  = 11'd1;
        end else if (to_q == TO_HIT && !coast_q) begin
          // Coast also invalidates the period so the next rise only restarts it.
          upd_d     = 1'b1;
          upd_spd_d = '0;
          coast_d   = 1'b1;
          pvld_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        if (&lvl) begin
          dir_err_d = 1'b1;
          stuck_d   = 1'b0;
          state_d   = IDLE;
        end else if (act_fall) begin
          if (!stuck_q) begin
            upd_d     = 1'b1;
            upd_spd_d = spd_of(rev, hcnt_q);
          end
          stuck_d = 1'b0;
          if (oth_rise) begin
            state_d = rev ? HIGH_FWD : HIGH_REV;
            hcnt_d  = 11'd1;
          end else begin
            state_d = LOW;
          end
        end else begin
          if (act_lvl && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 11'd1;
          if (to_q == TO_HIT && !stuck_q) begin
            upd_d     = 1'b1;
            upd_spd_d = spd_of(rev, CNT_MAX);
            stuck_d   = 1'b1;
          end
        end
      end
    endcase

    if (state_d != state_q) to_d = '0;

    spd_d     = upd_q ? upd_spd_q : spd_q;
    spd_vld_d = upd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      to_q      <= '0;
      pcnt_q    <= '0;
      pvld_q    <= 1'b0;
      period_q  <= '0;
      upd_q     <= 1'b0;
      upd_spd_q <= '0;
      spd_q     <= '0;
      spd_vld_q <= 1'b0;
      coast_q   <= 1'b0;
      stuck_q   <= 1'b0;
      dir_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      to_q      <= to_d;
      pcnt_q    <= pcnt_d;
      pvld_q    <= pvld_d;
      period_q  <= period_d;
      upd_q     <= upd_d;
      upd_spd_q <= upd_spd_d;
      spd_q     <= spd_d;
      spd_vld_q <= spd_vld_d;
      coast_q   <= coast_d;
      stuck_q   <= stuck_d;
      dir_err_q <= dir_err_d;
    end
  end

  assign spd     = spd_q;
  assign spd_vld = spd_vld_q;
  assign period  = period_q;
  assign coast   = coast_q;
  assign stuck   = stuck_q;
  assign dir_err = dir_err_q;
endmodule

// File: tb/tb_pwm_dcdr.sv
// Scenario bench for pwm_dcdr: expected speeds are queued as pulses are driven
// and popped whenever spd_vld is seen.
module tb_pwm_dcdr;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               PWM1 = 1'b0;
  logic               PWM2 = 1'b0;
  logic signed [11:0] spd;
  logic               spd_vld;
  logic [11:0]        period;
  logic               coast, stuck, dir_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vld_cyc = 0;
  logic signed [11:0] exp_q[$];

  pwm_dcdr dut (
    .clk(clk), .rst(rst), .PWM1(PWM1), .PWM2(PWM2),
    .spd(spd), .spd_vld(spd_vld), .period(period),
    .coast(coast), .stuck(stuck), .dir_err(dir_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; any spd_vld pulse is checked against the scoreboard.
  task automatic tick();
    logic signed [11:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (spd_vld === 1'b1) begin
      vld_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spd_vld_unexpected: got pulse with spd=%0d, want no pulse", spd);
      end else begin
        e = exp_q.pop_front();
        if (spd !== e) begin
          n_fail++;
          $display("FAIL spd_value: got %0d, want %0d", spd, e);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    n_tests++;
    if ({spd, period, spd_vld, coast, stuck, dir_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got spd=%0d period=%0d vld=%b coast=%b stuck=%b dir_err=%b, want all 0",
               spd, period, spd_vld, coast, stuck, dir_err);
    end
    rst = 1'b0;
    ticks(4);
  endtask

  task automatic test_fwd();
    int f;
    for (int p = 0; p < 3; p++) begin
      PWM1 = 1'b1;
      exp_q.push_back(12'sd512);
      ticks(512);
      n_tests++;
      if (p == 0) begin
        if (period !== 12'd0) begin
          n_fail++;
          $display("FAIL period_first_rise: got %0d, want 0", period);
        end
      end else if (period !== 12'd2048) begin
        n_fail++;
        $display("FAIL period_fwd: got %0d, want 2048", period);
      end
      PWM1 = 1'b0;
      f = cyc;
      ticks(1536);
      n_tests++;
      if (vld_cyc - f !== 4) begin
        n_fail++;
        $display("FAIL fall_latency: got %0d clk, want 4 clk", vld_cyc - f);
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fwd_missing_vld: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_rev_coast();
    for (int p = 0; p < 2; p++) begin
      PWM2 = 1'b1;
      exp_q.push_back(12'shC17);
      ticks(1000);
      PWM2 = 1'b0;
      if (p == 0) ticks(1048);
    end
    n_tests++;
    if (period !== 12'd2048) begin
      n_fail++;
      $display("FAIL period_rev: got %0d, want 2048", period);
    end
    ticks(4000);
    n_tests++;
    if (coast !== 1'b0) begin
      n_fail++;
      $display("FAIL coast_early: got %b, want 0", coast);
    end
    exp_q.push_back(12'sd0);
    ticks(200);
    n_tests++;
    if (coast !== 1'b1) begin
      n_fail++;
      $display("FAIL coast_set: got %b, want 1", coast);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rev_missing_vld: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stuck();
    PWM1 = 1'b1;
    exp_q.push_back(12'sd2047);
    ticks(4000);
    n_tests++;
    if (stuck !== 1'b0 || coast !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_early: got stuck=%b coast=%b, want 0 0", stuck, coast);
    end
    n_tests++;
    if (period !== 12'd2048) begin
      n_fail++;
      $display("FAIL period_after_coast: got %0d, want 2048", period);
    end
    ticks(1000);
    n_tests++;
    if (stuck !== 1'b1 || spd !== 12'sd2047) begin
      n_fail++;
      $display("FAIL stuck_set: got stuck=%b spd=%0d, want 1 2047", stuck, spd);
    end
    PWM1 = 1'b0;
    ticks(10);
    n_tests++;
    if (stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_clear: got %b, want 0", stuck);
    end
    ticks(50);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stuck_missing_vld: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_dir_err();
    PWM1 = 1'b1;
    ticks(20);
    PWM2 = 1'b1;
    ticks(3);
    PWM1 = 1'b0;
    ticks(10);
    PWM2 = 1'b0;
    ticks(20);
    n_tests++;
    if (dir_err !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_err_set: got %b, want 1", dir_err);
    end
    PWM1 = 1'b1;
    exp_q.push_back(12'sd100);
    ticks(100);
    PWM1 = 1'b0;
    ticks(100);
    n_tests++;
    if (dir_err !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_err_sticky: got %b, want 1", dir_err);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL dir_missing_vld: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    PWM1 = 1'b1;
    ticks(300);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({spd, period, spd_vld, coast, stuck, dir_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got spd=%0d period=%0d vld=%b coast=%b stuck=%b dir_err=%b, want all 0",
               spd, period, spd_vld, coast, stuck, dir_err);
    end
    ticks(2);
    rst = 1'b0;
    ticks(398);
    PWM1 = 1'b0;
    ticks(100);
    PWM1 = 1'b1;
    exp_q.push_back(12'sd700);
    ticks(700);
    n_tests++;
    if (period !== 12'd0) begin
      n_fail++;
      $display("FAIL period_after_reset: got %0d, want 0", period);
    end
    PWM1 = 1'b0;
    ticks(50);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_missing_vld: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    PWM1 = 1'b1;
    exp_q.push_back(12'sd300);
    ticks(300);
    PWM1 = 1'b0;
    PWM2 = 1'b1;
    exp_q.push_back(-12'sd201);
    ticks(200);
    n_tests++;
    if (period !== 12'd300) begin
      n_fail++;
      $display("FAIL period_b2b: got %0d, want 300", period);
    end
    PWM2 = 1'b0;
    ticks(50);
    n_tests++;
    if (dir_err !== 1'b0 || spd !== -12'sd201) begin
      n_fail++;
      $display("FAIL b2b_final: got dir_err=%b spd=%0d, want 0 -201", dir_err, spd);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing_vld: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_rev_coast();
    test_stuck();
    test_dir_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_dcdr.md
PWM_DCDR -- requirements
Module: pwm_dcdr

Interface
REQ-001 Parameter PERIOD, default 2048: nominal PWM period in clk cycles (11-bit PWM).
REQ-002 Parameter TIMEOUT, default 4096: clk cycles without a qualifying edge before coast or stuck is declared.
REQ-003 clk  input  1  system clock; one clock; all state rising-edge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 PWM1  input  1  forward-drive PWM from H-bridge driver; asynchronous.
REQ-006 PWM2  input  1  reverse-drive PWM from H-bridge driver; asynchronous.
REQ-007 spd  output  12  signed reconstructed speed; forward = +high_cnt, reverse = ~{1'b0,high_cnt}.
REQ-008 spd_vld  output  1  one-clk pulse when spd updates.
REQ-009 period  output  12  clk cycles between the last two rising edges, saturating at 4095.
REQ-010 coast  output  1  no pulse seen for TIMEOUT cycles.
REQ-011 stuck  output  1  active PWM held high for TIMEOUT cycles.
REQ-012 dir_err  output  1  sticky; PWM1 and PWM2 were both high after synchronization.

Function
REQ-013 Each PWM input SHALL pass through two synchronizer flops plus one edge-detect flop; rise = s2&~s3, fall = ~s2&s3.
REQ-014 FSM states SHALL be IDLE, HIGH_FWD, HIGH_REV, LOW.
REQ-015 IDLE/LOW -> HIGH_FWD on PWM1 rise, -> HIGH_REV on PWM2 rise; high_cnt loads 1 on that cycle.
REQ-016 In HIGH_x, high_cnt SHALL increment once per cycle that the synced active signal is 1, saturating at 2047.
REQ-017 HIGH_x -> LOW on active fall; spd SHALL update and spd_vld SHALL pulse on the clk after the fall is detected (total latency from pin fall: 4 clk).
REQ-018 HIGH_FWD SHALL output spd = {1'b0,high_cnt}; HIGH_REV SHALL output spd = ~{1'b0,high_cnt} (e.g. cnt 1 gives -2, cnt 2047 gives -2048).
REQ-019 On each rise, period SHALL latch the rise-to-rise cycle count and the count restarts at 1; the first rise after reset or coast leaves period unchanged.
REQ-020 If timeout_cnt reaches TIMEOUT in IDLE or LOW: spd = 0, one spd_vld pulse, coast = 1, go to IDLE; coast clears on the next rise.
REQ-021 If timeout_cnt reaches TIMEOUT in HIGH_x: spd = +2047 (FWD) or -2048 (REV), one spd_vld pulse, stuck = 1, stay in HIGH_x; stuck clears on the fall, and that fall produces no second spd_vld.
REQ-022 timeout_cnt SHALL clear on any rise and on every transition, and saturate at TIMEOUT.
REQ-023 Synced PWM1 & PWM2 both high SHALL set dir_err, go to IDLE, and suppress spd_vld for that pulse; dir_err clears only on rst.
REQ-024 A rise of the inactive signal while in HIGH_x SHALL be handled as REQ-023.
REQ-025 Simultaneous fall of the active signal and rise of the other SHALL complete the update (REQ-017) and then enter the new HIGH state on the same edge.

Reset
REQ-026 rst SHALL asynchronously force: FSM to IDLE, all synchronizer flops to 0, high_cnt, timeout_cnt and period counter to 0, spd = 0, period = 0, spd_vld = 0, coast = 0, stuck = 0, dir_err = 0.
REQ-027 rst asserted mid-pulse SHALL discard the partial count; after release, measurement restarts at the next rise only.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, PERIOD/TIMEOUT defaults, and the 12-bit signed speed typedef shared with the motor driver.
REQ-029 One sub-module, pwm_sync_edge (synchronizer plus rise/fall detect), SHALL be instantiated once per PWM input.

Verification
REQ-030 PWM1 high 512 of every 2048 clk -> spd=+512, spd_vld pulse 4 clk after each fall, period=2048 from the second pulse on.
REQ-031 PWM2 high 1000 of every 2048 clk -> spd=-1001 (0xC17); PWM1 and PWM2 held 0 for 4096 clk -> spd=0, coast=1, one spd_vld pulse.
REQ-032 PWM1 held high for 5000 clk -> spd=+2047 and stuck=1 at the 4096th high cycle; on the fall, stuck=0 and no extra spd_vld.
REQ-033 PWM1 and PWM2 overlap high 3 clk -> dir_err=1 and stays 1, no spd_vld for that pulse; next clean PWM1 pulse of 100 -> spd=+100.
REQ-034 rst pulsed during a 700-clk PWM1 high phase -> all outputs 0 immediately; remainder of that pulse ignored; next full 700-clk pulse -> spd=+700.
REQ-035 PWM1 falls on the same clk that PWM2 rises, durations 300 then 200 -> spd=+300 then spd=-201, no dir_err.
